// File: rtl/pixel_compositor_pipe_pkg.sv
// Shared pixel types, colour constants and sizing helper for the compositor.
package gpu_pkg;

  typedef logic [11:0] pixel_t;

  localparam pixel_t GREEN   = 12'h0F0;
  localparam pixel_t BLACK   = 12'h000;
  localparam pixel_t MAGENTA = 12'hF0F;

  // Index width that never collapses to zero bits for tiny channel counts.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_compositor_pipe_prio_tree.sv
// Combinational max-level tree: winning index, any-active flag and a
// two-or-more-active flag. Lower index wins on equal levels.
module pixel_prio_tree
  import gpu_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LEVEL_W = 4,
  parameter int unsigned IDX_W   = clog2_safe(WIDTH)
) (
  input  logic [WIDTH-1:0]         active_i,
  input  logic [WIDTH*LEVEL_W-1:0] level_i,
  output logic [IDX_W-1:0]         winner_o,
  output logic                     any_o,
  output logic                     multi_o
);

  localparam int unsigned P = 1 << IDX_W;

  // Heap layout: node n has children 2n (lower indices) and 2n+1; leaves at P+i.
  always_comb begin
    logic [LEVEL_W-1:0] nl [2*P];
    logic [IDX_W-1:0]   ni [2*P];
    logic               na [2*P];
    logic               nm [2*P];
    logic               take_l;
    take_l = 1'b0;
    for (int unsigned n = 0; n < 2*P; n++) begin
      nl[n] = '0;
      ni[n] = '0;
      na[n] = 1'b0;
      nm[n] = 1'b0;
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      na[P+i] = active_i[i];
      nl[P+i] = level_i[i*LEVEL_W +: LEVEL_W];
      ni[P+i] = IDX_W'(i);
    end
    for (int unsigned n = P - 1; n >= 1; n--) begin
      take_l = na[2*n] && (!na[2*n+1] || (nl[2*n] >= nl[2*n+1]));
      nl[n]  = take_l ? nl[2*n] : nl[2*n+1];
      ni[n]  = take_l ? ni[2*n] : ni[2*n+1];
      na[n]  = na[2*n] || na[2*n+1];
      nm[n]  = nm[2*n] || nm[2*n+1] || (na[2*n] && na[2*n+1]);
    end
    winner_o = ni[1];
    any_o    = na[1];
    multi_o  = nm[1];
  end

endmodule

// File: rtl/pixel_compositor_pipe.sv
// Two-stage N-layer pixel compositor with collision statistics.
// Optional build macro COMPOSITOR_COLORKEY_EN: KEY_COLOR pixels count as inactive.
module pixel_compositor_pipe
  import gpu_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LEVEL_W    = 4,
  parameter int unsigned CNT_W      = 16,
  parameter pixel_t      BACKGROUND = GREEN,
  parameter pixel_t      KEY_COLOR  = MAGENTA,
  localparam int unsigned IDX_W     = clog2_safe(WIDTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pix_valid,
  input  logic                     frame_start,
  input  logic [WIDTH-1:0]         enable,
  input  logic [WIDTH*LEVEL_W-1:0] level,
  input  logic [WIDTH*12-1:0]      pixel,
  output logic [11:0]              out_pixel,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_winner,
  output logic                     out_collide,
  output logic [CNT_W-1:0]         collision_cnt,
  output logic [CNT_W-1:0]         collision_frame,
  output logic [WIDTH-1:0]         collide_mask
);

`ifdef COMPOSITOR_COLORKEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic [WIDTH-1:0]         active_d;
  logic                     v1_q, fs1_q;
  logic [WIDTH-1:0]         active1_q;
  logic [WIDTH*LEVEL_W-1:0] level1_q;
  logic [WIDTH*12-1:0]      pixel1_q;

  always_comb begin
    active_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      active_d[i] = enable[i] && (!KEY_EN || (pixel[i*12 +: 12] != KEY_COLOR));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q      <= 1'b0;
      fs1_q     <= 1'b0;
      active1_q <= '0;
      level1_q  <= '0;
      pixel1_q  <= '0;
    end else begin
      v1_q      <= pix_valid;
      fs1_q     <= frame_start && pix_valid;
      active1_q <= active_d;
      level1_q  <= level;
      pixel1_q  <= pixel;
    end
  end

  logic [IDX_W-1:0] win;
  logic             any_act, multi;

  pixel_prio_tree #(
    .WIDTH  (WIDTH),
    .LEVEL_W(LEVEL_W),
    .IDX_W  (IDX_W)
  ) u_tree (
    .active_i(active1_q),
    .level_i (level1_q),
    .winner_o(win),
    .any_o   (any_act),
    .multi_o (multi)
  );

  pixel_t           pix_d;
  logic [IDX_W-1:0] win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, frame_q, frame_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  pixel_t           pix_q;
  logic [IDX_W-1:0] win_q;
  logic             valid_q, collide_q;

  always_comb begin
    pix_d = BACKGROUND;
    win_d = '0;
    if (any_act) begin
      win_d = win;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (IDX_W'(i) == win) pix_d = pixel1_q[i*12 +: 12];
      end
    end
  end

  // A frame_start pixel closes the old frame and seeds the new one with itself.
  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    mask_d  = mask_q;
    if (v1_q) begin
      if (fs1_q) begin
        frame_d = cnt_q;
        cnt_d   = multi ? CNT_W'(1) : '0;
        mask_d  = multi ? active1_q : '0;
      end else if (multi) begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        mask_d = mask_q | active1_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pix_q     <= BACKGROUND;
      win_q     <= '0;
      collide_q <= 1'b0;
      cnt_q     <= '0;
      frame_q   <= '0;
      mask_q    <= '0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        pix_q     <= pix_d;
        win_q     <= win_d;
        collide_q <= multi;
      end
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      mask_q  <= mask_d;
    end
  end

  assign out_pixel       = pix_q;
  assign out_valid       = valid_q;
  assign out_winner      = win_q;
  assign out_collide     = collide_q;
  assign collision_cnt   = cnt_q;
  assign collision_frame = frame_q;
  assign collide_mask    = mask_q;

endmodule
